// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the 4-channel TDM link (demux and the
// matching transmitter).
//   NCH          number of time slots per frame
//   slot_t       2-bit slot index
//   tdm_state_t  receiver frame-alignment state
//   next_slot()  modulo-NCH slot increment
package tdm_pkg;

  localparam int NCH = 4;

  typedef logic [1:0] slot_t;

  // Legacy-compatible state encodings, also available as an enum type.
  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef enum logic [0:0] {
    HUNT   = ST_HUNT,
    LOCKED = ST_LOCKED
  } tdm_state_t;

  // Slot 3 wraps to 0; the 2-bit index makes the modulo implicit.
  function automatic slot_t next_slot(input slot_t s);
    return slot_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/tdm_demux41.sv
// tdm_demux41: receive end of a 4-channel TDM link.
// One WIDTH-bit sample is taken from din in every cycle with en=1. fsync marks
// slot 0; the first fsync seen in HUNT aligns the frame. Slots 0..2 are kept
// in holding registers and the slot-3 sample commits the whole frame to
// ch0..ch3 at once, so the outputs never show a partial frame.
//
// Handshake: there is no backpressure. en is a one-cycle strobe qualifying
// din/fsync; a sample is consumed at every rising edge where en=1 and the
// receiver is not in reset. With en=0 nothing changes and fsync is ignored.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   din          TDM sample line
//   en           sample strobe
//   fsync        frame sync, marks the slot-0 sample of the same cycle
//   ch0..ch3     channel values of the last complete frame
//   frame_valid  one-cycle pulse, ch0..ch3 were updated
//   slot         slot index the next accepted sample will occupy
//   locked       1 while the receiver is frame-aligned (FSM state)
//   sync_err     one-cycle pulse, fsync arrived mid-frame (resync done)
module tdm_demux41
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             fsync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  tdm_state_t       state;
  slot_t            slot_q;
  logic [WIDTH-1:0] hold0;
  logic [WIDTH-1:0] hold1;
  logic [WIDTH-1:0] hold2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot_q      <= '0;
      hold0       <= '0;
      hold1       <= '0;
      hold2       <= '0;
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      // Both flags are single-cycle pulses.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (en) begin
        if (state == HUNT) begin
          // Samples before the first fsync cannot be placed; drop them.
          if (fsync) begin
            hold0  <= din;
            slot_q <= 2'd1;
            state  <= LOCKED;
          end
        end else if (fsync && (slot_q != 2'd0)) begin
          // Resync: abandon the partial frame and restart at slot 0 with this
          // sample. Stale hold1/hold2 are overwritten before the next commit.
          hold0    <= din;
          slot_q   <= 2'd1;
          sync_err <= 1'b1;
        end else begin
          // Aligned sample (fsync optional at slot 0: a missing marker does
          // not drop lock).
          unique case (slot_q)
            2'd0: hold0 <= din;
            2'd1: hold1 <= din;
            2'd2: hold2 <= din;
            2'd3: begin
              ch0         <= hold0;
              ch1         <= hold1;
              ch2         <= hold2;
              ch3         <= din;
              frame_valid <= 1'b1;
            end
            default: ;
          endcase
          slot_q <= next_slot(slot_q);
        end
      end
    end
  end

  assign slot   = slot_q;
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux41.sv
// Directed bench for tdm_demux41 (WIDTH=4). A small reference model tracks
// lock state, slot and held samples; completed frames are pushed to exp_q
// and popped when the DUT pulses frame_valid.
module tb_tdm_demux41;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         en;
  logic         fsync;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic         frame_valid;
  logic [1:0]   slot;
  logic         locked;
  logic         sync_err;

  always #5 clk = ~clk;

  tdm_demux41 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .en          (en),
    .fsync       (fsync),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  // ---------------- scoreboard / model ----------------
  logic [4*W-1:0] exp_q[$];
  logic [4*W-1:0] last_ch;
  logic           m_locked;
  logic [1:0]     m_slot;
  logic [W-1:0]   m_hold0, m_hold1, m_hold2;
  logic           m_fv, m_se;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_slot   = 2'd0;
    m_hold0  = '0;
    m_hold1  = '0;
    m_hold2  = '0;
    last_ch  = '0;
    exp_q.delete();
  endtask

  // Checks every output after the edge that consumed the driven inputs.
  task automatic check_outputs();
    logic [4*W-1:0] exp_frame;
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("sync_err", 32'(sync_err), 32'(m_se));
    chk("slot", 32'(slot), 32'(m_slot));
    chk("locked", 32'(locked), 32'(m_locked));
    if (frame_valid) begin
      if (exp_q.size() == 0) begin
        chk("frame_unexpected", 32'({ch0, ch1, ch2, ch3}), 32'hFFFF_FFFF);
      end else begin
        exp_frame = exp_q.pop_front();
        chk("frame_data", 32'({ch0, ch1, ch2, ch3}), 32'(exp_frame));
        last_ch = exp_frame;
      end
    end else begin
      chk("ch_hold", 32'({ch0, ch1, ch2, ch3}), 32'(last_ch));
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic e, input logic f, input logic [W-1:0] d);
    en = e; fsync = f; din = d;
    m_fv = 1'b0;
    m_se = 1'b0;
    if (e) begin
      if (!m_locked) begin
        if (f) begin
          m_hold0 = d; m_slot = 2'd1; m_locked = 1'b1;
        end
      end else if (f && m_slot != 2'd0) begin
        m_hold0 = d; m_slot = 2'd1; m_se = 1'b1;
      end else begin
        case (m_slot)
          2'd0: m_hold0 = d;
          2'd1: m_hold1 = d;
          2'd2: m_hold2 = d;
          default: begin
            exp_q.push_back({m_hold0, m_hold1, m_hold2, d});
            m_fv = 1'b1;
          end
        endcase
        m_slot = m_slot + 2'd1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic e, input logic f, input logic [W-1:0] d);
    rst = 1'b1; en = e; fsync = f; din = d;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    m_fv = 1'b0;
    m_se = 1'b0;
    chk("rst_outputs", 32'({ch0, ch1, ch2, ch3}), 32'h0);
    check_outputs();
  endtask

  task automatic gap();
    step(1'b0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; fsync = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset(1'b0, 1'b0, '0);

    // Reset then lock: A,B,C,D with fsync on A.
    step(1, 1, 4'hA);
    step(1, 0, 4'hB);
    step(1, 0, 4'hC);
    step(1, 0, 4'hD);
    chk("lock_frame", 32'({ch0, ch1, ch2, ch3}), 32'hABCD);
    step(0, 0, 4'h0);

    // HUNT discard after a fresh reset.
    do_reset(1'b1, 1'b1, 4'hF);
    step(1, 0, 4'h1);
    step(1, 0, 4'h2);
    step(1, 0, 4'h3);
    chk("hunt_locked", 32'(locked), 32'h0);
    step(1, 1, 4'h5);
    step(1, 0, 4'h6);
    step(1, 0, 4'h7);
    step(1, 0, 4'h8);
    chk("hunt_frame", 32'({ch0, ch1, ch2, ch3}), 32'h5678);

    // Mid-frame resync.
    step(1, 0, 4'h1);
    step(1, 0, 4'h2);
    step(1, 1, 4'h9);
    chk("resync_err", 32'(sync_err), 32'h1);
    step(1, 0, 4'hA);
    chk("resync_err_clear", 32'(sync_err), 32'h0);
    step(1, 0, 4'hB);
    step(1, 0, 4'hC);
    chk("resync_frame", 32'({ch0, ch1, ch2, ch3}), 32'h9ABC);

    // fsync=0 at slot 0 is accepted; gapped strobe with random gap data.
    step(1, 0, 4'h3); gap(); gap();
    step(1, 0, 4'h4); gap(); gap();
    step(1, 0, 4'h5); gap(); gap();
    step(1, 0, 4'h6);
    chk("gap_frame", 32'({ch0, ch1, ch2, ch3}), 32'h3456);
    gap();

    // Reset mid-frame (en high during reset), then a non-fsync sample is dropped.
    step(1, 1, 4'hA);
    step(1, 0, 4'hB);
    step(1, 0, 4'hC);
    step(1, 0, 4'hD);
    step(1, 0, 4'h1);
    step(1, 0, 4'h2);
    do_reset(1'b1, 1'b0, 4'h3);
    chk("rst_locked", 32'(locked), 32'h0);
    step(1, 0, 4'h4);

    // Continuous streaming: 3 back-to-back frames, fsync on each slot 0.
    for (int fr = 0; fr < 3; fr++) begin
      for (int s = 0; s < 4; s++) begin
        step(1, (s == 0), W'($urandom_range(0, 15)));
      end
    end
    // Random stream with random fsync placement.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           W'($urandom_range(0, 15)));
    end

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
